dca_matrix_register_type2: RTL and testbench

//  Rectangular NUM_ROW x NUM_COL tensor register for the DCA datapath, holding one operand tile.

---
 rtl/dca_matrix_register_type2_pkg.sv | 31 +++
 rtl/dca_matrix_row_stream_ctrl.sv | 132 +++++++++++++
 rtl/dca_matrix_register_type2.sv | 114 +++++++++++
 tb/tb_dca_matrix_register_type2.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_register_type2_pkg.sv
// Shared types for the rectangular DCA tile register: stream FSM states,
// per-cycle tile operation select and a constant-width helper.
package dca_matrix_register_type2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } stream_state_e;

    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_INIT       = 3'd1,
        OP_WRITE_ALL  = 3'd2,
        OP_TRANSPOSE  = 3'd3,
        OP_SHIFT_UP   = 3'd4,
        OP_SHIFT_LEFT = 3'd5,
        OP_LOAD_BEAT  = 3'd6,
        OP_ROTATE     = 3'd7
    } tile_op_e;

    function automatic int clog2_fn(input int value);
        int bits;
        bits = 32'sd0;
        while ((32'sd1 << bits) < value) begin
            bits = bits + 32'sd1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/dca_matrix_row_stream_ctrl.sv
// Row-stream controller: IDLE/LOAD/STORE FSM, beat counter, handshake
// outputs, done/cmd_error pulses and the tile operation chosen each cycle.
module dca_matrix_row_stream_ctrl
    import dca_matrix_register_type2_pkg::*;
#(
    parameter int NUM_ROW = 8,
    parameter int NUM_COL = 8
) (
    input  logic     clk,
    input  logic     rstnn,
    input  logic     init,
    input  logic     all_wenable,
    input  logic     shift_up,
    input  logic     shift_left,
    input  logic     transpose,
    input  logic     load_start,
    input  logic     load_valid,
    input  logic     store_start,
    input  logic     store_ready,
    output tile_op_e op,
    output logic     load_ready,
    output logic     store_valid,
    output logic     store_last,
    output logic     busy,
    output logic     done,
    output logic     cmd_error
);

    localparam int CNT_W = clog2_fn(NUM_ROW + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_ROW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam bit IS_SQUARE = (NUM_ROW == NUM_COL);

    stream_state_e    state_r, state_next_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_next_s;
    logic             done_r, done_next_s;
    logic             cmd_error_r, cmd_error_next_s;
    tile_op_e         op_s;
    logic             below_init_s;
    logic             beat_s;

    assign below_init_s = all_wenable | load_start | store_start | transpose | shift_up | shift_left;
    assign beat_s       = (state_r == ST_LOAD) ? load_valid : store_ready;

    // State, beat counter and one-cycle status pulses.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_r     <= ST_IDLE;
            beat_cnt_r  <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
            cmd_error_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            beat_cnt_r  <= beat_cnt_next_s;
            done_r      <= done_next_s;
            cmd_error_r <= cmd_error_next_s;
        end
    end

    // Command arbitration; every command losing priority is reported, not queued.
    always_comb begin
        state_next_s     = state_r;
        beat_cnt_next_s  = beat_cnt_r;
        done_next_s      = 1'b0;
        cmd_error_next_s = 1'b0;
        op_s             = OP_HOLD;
        case (state_r)
            ST_IDLE: begin
                if (init) begin
                    op_s             = OP_INIT;
                    cmd_error_next_s = below_init_s;
                end else if (all_wenable) begin
                    op_s             = OP_WRITE_ALL;
                    cmd_error_next_s = load_start | store_start | transpose | shift_up | shift_left;
                end else if (load_start) begin
                    state_next_s     = ST_LOAD;
                    beat_cnt_next_s  = {CNT_W{1'b0}};
                    cmd_error_next_s = store_start | transpose | shift_up | shift_left;
                end else if (store_start) begin
                    state_next_s     = ST_STORE;
                    beat_cnt_next_s  = {CNT_W{1'b0}};
                    cmd_error_next_s = transpose | shift_up | shift_left;
                end else if (transpose) begin
                    op_s             = IS_SQUARE ? OP_TRANSPOSE : OP_HOLD;
                    cmd_error_next_s = !IS_SQUARE | shift_up | shift_left;
                end else if (shift_up) begin
                    op_s             = OP_SHIFT_UP;
                    cmd_error_next_s = shift_left;
                end else if (shift_left) begin
                    op_s = OP_SHIFT_LEFT;
                end else begin
                    op_s = OP_HOLD;
                end
            end
            ST_LOAD, ST_STORE: begin
                if (init) begin
                    state_next_s     = ST_IDLE;
                    beat_cnt_next_s  = {CNT_W{1'b0}};
                    op_s             = OP_INIT;
                    cmd_error_next_s = below_init_s;
                end else begin
                    cmd_error_next_s = below_init_s;
                    if (beat_s) begin
                        op_s = (state_r == ST_LOAD) ? OP_LOAD_BEAT : OP_ROTATE;
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_next_s    = ST_IDLE;
                            beat_cnt_next_s = {CNT_W{1'b0}};
                            done_next_s     = 1'b1;
                        end else begin
                            beat_cnt_next_s = beat_cnt_r + CNT_ONE;
                        end
                    end else begin
                        op_s = OP_HOLD;
                    end
                end
            end
            default: begin
                state_next_s    = ST_IDLE;
                beat_cnt_next_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign op          = op_s;
    assign load_ready  = (state_r == ST_LOAD);
    assign store_valid = (state_r == ST_STORE);
    assign store_last  = (state_r == ST_STORE) && (beat_cnt_r == LAST_BEAT);
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign cmd_error   = cmd_error_r;

endmodule

// File: rtl/dca_matrix_register_type2.sv
// Rectangular NUM_ROW x NUM_COL operand tile register with parallel access,
// row shifts, square transpose and valid/ready row streaming.
module dca_matrix_register_type2
    import dca_matrix_register_type2_pkg::*;
#(
    parameter int NUM_ROW          = 8,
    parameter int NUM_COL          = 8,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = {BW_TENSOR_SCALAR{1'b0}},
    parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE  = RESET_VALUE,
    parameter logic [BW_TENSOR_SCALAR-1:0] FILL_VALUE  = {BW_TENSOR_SCALAR{1'b0}}
) (
    input  logic                                          clk,
    input  logic                                          rstnn,
    input  logic                                          init,
    input  logic                                          all_wenable,
    input  logic [NUM_ROW*NUM_COL*BW_TENSOR_SCALAR-1:0]   all_wdata_list2d,
    input  logic                                          shift_up,
    input  logic                                          shift_left,
    input  logic                                          transpose,
    input  logic                                          load_start,
    input  logic                                          load_valid,
    output logic                                          load_ready,
    input  logic [NUM_COL*BW_TENSOR_SCALAR-1:0]           load_wdata_list1d,
    input  logic                                          store_start,
    output logic                                          store_valid,
    input  logic                                          store_ready,
    output logic [NUM_COL*BW_TENSOR_SCALAR-1:0]           store_rdata_list1d,
    output logic                                          store_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          cmd_error,
    output logic [NUM_ROW*NUM_COL*BW_TENSOR_SCALAR-1:0]   all_rdata_list2d
);

    localparam int BW               = BW_TENSOR_SCALAR;
    localparam int BW_TENSOR_ROW    = NUM_COL * BW;
    localparam int BW_TENSOR_MATRIX = NUM_ROW * NUM_COL * BW;

    logic [BW-1:0] elem_r      [NUM_ROW][NUM_COL];
    logic [BW-1:0] elem_next_s [NUM_ROW][NUM_COL];
    tile_op_e      op_s;

    dca_matrix_row_stream_ctrl #(
        .NUM_ROW (NUM_ROW),
        .NUM_COL (NUM_COL)
    ) u_ctrl (
        .clk         (clk),
        .rstnn       (rstnn),
        .init        (init),
        .all_wenable (all_wenable),
        .shift_up    (shift_up),
        .shift_left  (shift_left),
        .transpose   (transpose),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .store_start (store_start),
        .store_ready (store_ready),
        .op          (op_s),
        .load_ready  (load_ready),
        .store_valid (store_valid),
        .store_last  (store_last),
        .busy        (busy),
        .done        (done),
        .cmd_error   (cmd_error)
    );

    // Per-element next value; the modulo indices only matter for ops that
    // wrap (rotate) and keep non-square transpose indices in range.
    always_comb begin
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                elem_next_s[r][c] = elem_r[r][c];
                case (op_s)
                    OP_INIT:       elem_next_s[r][c] = INIT_VALUE;
                    OP_WRITE_ALL:  elem_next_s[r][c] = all_wdata_list2d[(r*NUM_COL+c)*BW +: BW];
                    OP_TRANSPOSE:  elem_next_s[r][c] = elem_r[c % NUM_ROW][r % NUM_COL];
                    OP_SHIFT_UP:   elem_next_s[r][c] = (r == NUM_ROW-1) ? FILL_VALUE
                                                                        : elem_r[(r+1) % NUM_ROW][c];
                    OP_SHIFT_LEFT: elem_next_s[r][c] = (c == NUM_COL-1) ? FILL_VALUE
                                                                        : elem_r[r][(c+1) % NUM_COL];
                    OP_LOAD_BEAT:  elem_next_s[r][c] = (r == NUM_ROW-1) ? load_wdata_list1d[c*BW +: BW]
                                                                        : elem_r[(r+1) % NUM_ROW][c];
                    OP_ROTATE:     elem_next_s[r][c] = elem_r[(r+1) % NUM_ROW][c];
                    default:       elem_next_s[r][c] = elem_r[r][c];
                endcase
            end
        end
    end

    // Element storage.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int r = 0; r < NUM_ROW; r++) begin
                for (int c = 0; c < NUM_COL; c++) begin
                    elem_r[r][c] <= RESET_VALUE;
                end
            end
        end else begin
            elem_r <= elem_next_s;
        end
    end

    for (genvar gr = 0; gr < NUM_ROW; gr++) begin : g_row
        for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_col
            assign all_rdata_list2d[(gr*NUM_COL+gc)*BW +: BW] = elem_r[gr][gc];
        end
    end

    for (genvar gc = 0; gc < NUM_COL; gc++) begin : g_store
        assign store_rdata_list1d[gc*BW +: BW] = elem_r[0][gc];
    end

endmodule

// File: tb/tb_dca_matrix_register_type2.sv
// Scoreboard bench: stimulus queues expected beats/pulses/tiles, a negedge
// monitor pops and compares whenever the DUTs present them.
module tb_dca_matrix_register_type2;

    localparam int AR = 4, AC = 6, BW = 8;
    localparam int AROW = AC*BW, ATILE = AR*AC*BW;
    localparam int BR = 8, BC = 8, BTILE = BR*BC*BW;
    localparam int EV_BEAT = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct {
        int              kind;
        logic [AROW-1:0] row;
        logic            last;
    } ev_t;

    logic clk = 1'b0;
    logic rstnn;
    always #5 clk = ~clk;

    logic             a_init, a_wen, a_su, a_sl, a_tr, a_ls, a_lv, a_ss, a_sr;
    logic [ATILE-1:0] a_wdata, a_rd;
    logic [AROW-1:0]  a_ld, a_sd;
    logic             a_lr, a_sv, a_last, a_busy, a_done, a_err;

    logic             b_wen, b_tr;
    logic [BTILE-1:0] b_wdata, b_rd;
    logic [BC*BW-1:0] b_sd;
    logic             b_lr, b_sv, b_last, b_busy, b_done, b_err;

    dca_matrix_register_type2 #(
        .NUM_ROW(AR), .NUM_COL(AC), .BW_TENSOR_SCALAR(BW),
        .RESET_VALUE(8'h00), .INIT_VALUE(8'h3C), .FILL_VALUE(8'hA5)
    ) dut_a (
        .clk(clk), .rstnn(rstnn), .init(a_init), .all_wenable(a_wen),
        .all_wdata_list2d(a_wdata), .shift_up(a_su), .shift_left(a_sl),
        .transpose(a_tr), .load_start(a_ls), .load_valid(a_lv),
        .load_ready(a_lr), .load_wdata_list1d(a_ld), .store_start(a_ss),
        .store_valid(a_sv), .store_ready(a_sr), .store_rdata_list1d(a_sd),
        .store_last(a_last), .busy(a_busy), .done(a_done),
        .cmd_error(a_err), .all_rdata_list2d(a_rd)
    );

    dca_matrix_register_type2 #(
        .NUM_ROW(BR), .NUM_COL(BC), .BW_TENSOR_SCALAR(BW)
    ) dut_b (
        .clk(clk), .rstnn(rstnn), .init(1'b0), .all_wenable(b_wen),
        .all_wdata_list2d(b_wdata), .shift_up(1'b0), .shift_left(1'b0),
        .transpose(b_tr), .load_start(1'b0), .load_valid(1'b0),
        .load_ready(b_lr), .load_wdata_list1d({BC*BW{1'b0}}), .store_start(1'b0),
        .store_valid(b_sv), .store_ready(1'b0), .store_rdata_list1d(b_sd),
        .store_last(b_last), .busy(b_busy), .done(b_done),
        .cmd_error(b_err), .all_rdata_list2d(b_rd)
    );

    ev_t              ev_q[$];
    logic [ATILE-1:0] tile_q[$];
    logic [BTILE-1:0] btile_q[$];
    logic             chk_a = 1'b0, chk_b = 1'b0;
    logic             exp_lr = 1'b0, exp_sv = 1'b0;
    int               errors = 0, checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [AROW-1:0] row, input logic last);
        ev_t e;
        e.kind = kind;
        e.row  = row;
        e.last = last;
        ev_q.push_back(e);
    endtask

    task automatic check_tile_a(input logic [ATILE-1:0] exp);
        tile_q.push_back(exp);
        chk_a = 1'b1;
        step();
        chk_a = 1'b0;
    endtask

    task automatic check_tile_b(input logic [BTILE-1:0] exp);
        btile_q.push_back(exp);
        chk_b = 1'b1;
        step();
        chk_b = 1'b0;
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        checks++;
        if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d, want none", kind);
        end else begin
            e = ev_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL sb_kind: got %0d want %0d", kind, e.kind);
            end else if (kind == EV_BEAT && (a_sd !== e.row || a_last !== e.last)) begin
                errors++;
                $display("FAIL store_beat: got row=%h last=%b want row=%h last=%b",
                         a_sd, a_last, e.row, e.last);
            end
        end
    endtask

    // Monitor: handshake flags every cycle, queued events when presented.
    always @(negedge clk) begin
        logic [ATILE-1:0] ea;
        logic [BTILE-1:0] eb;
        checks++;
        if ({a_lr, a_sv, a_busy} !== {exp_lr, exp_sv, exp_lr | exp_sv}) begin
            errors++;
            $display("FAIL a_flags: got lr/sv/busy=%b%b%b want %b%b%b",
                     a_lr, a_sv, a_busy, exp_lr, exp_sv, exp_lr | exp_sv);
        end
        if (a_sv && a_sr) sb_pop(EV_BEAT);
        if (a_done)       sb_pop(EV_DONE);
        if (a_err)        sb_pop(EV_ERR);
        if (chk_a) begin
            checks++;
            ea = tile_q.pop_front();
            if (a_rd !== ea) begin
                errors++;
                $display("FAIL tile_a: got %h want %h", a_rd, ea);
            end
        end
        checks++;
        if ({b_lr, b_sv, b_last, b_busy, b_done, b_err} !== 6'b000000) begin
            errors++;
            $display("FAIL b_flags: got %b want 000000", {b_lr, b_sv, b_last, b_busy, b_done, b_err});
        end
        if (chk_b) begin
            checks++;
            eb = btile_q.pop_front();
            if (b_rd !== eb) begin
                errors++;
                $display("FAIL tile_b: got %h want %h", b_rd, eb);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [ATILE-1:0] pat, ld_exp, exp;
        logic [BTILE-1:0] bpat, btr;

        {a_init, a_wen, a_su, a_sl, a_tr, a_ls, a_lv, a_ss, a_sr} = 9'b0;
        a_wdata = {ATILE{1'b0}};
        a_ld    = {AROW{1'b0}};
        {b_wen, b_tr} = 2'b00;
        b_wdata = {BTILE{1'b0}};
        rstnn   = 1'b0;
        for (int r = 0; r < AR; r++)
            for (int c = 0; c < AC; c++) begin
                pat[(r*AC+c)*BW +: BW]    = 8'(r*16 + c);
                ld_exp[(r*AC+c)*BW +: BW] = 8'(r + 1);
            end
        for (int r = 0; r < BR; r++)
            for (int c = 0; c < BC; c++) begin
                bpat[(r*BC+c)*BW +: BW] = 8'(r*8 + c);
                btr[(r*BC+c)*BW +: BW]  = 8'(c*8 + r);
            end
        repeat (3) step();
        rstnn = 1'b1;
        step();
        check_tile_a({ATILE{1'b0}});
        check_tile_b({BTILE{1'b0}});

        // 8x8 transpose
        b_wdata = bpat; b_wen = 1'b1; step(); b_wen = 1'b0;
        check_tile_b(bpat);
        b_tr = 1'b1; step(); b_tr = 1'b0;
        check_tile_b(btr);

        // parallel write then full non-destructive store
        a_wdata = pat; a_wen = 1'b1; step(); a_wen = 1'b0;
        check_tile_a(pat);
        for (int r = 0; r < AR; r++) push_ev(EV_BEAT, pat[r*AROW +: AROW], r == AR-1);
        push_ev(EV_DONE, {AROW{1'b0}}, 1'b0);
        a_ss = 1'b1; a_sr = 1'b1; step(); a_ss = 1'b0; exp_sv = 1'b1;
        repeat (AR) step();
        exp_sv = 1'b0; a_sr = 1'b0;
        check_tile_a(pat);

        // load with a gap before every beat
        push_ev(EV_DONE, {AROW{1'b0}}, 1'b0);
        a_ls = 1'b1; step(); a_ls = 1'b0; exp_lr = 1'b1;
        for (int k = 0; k < AR; k++) begin
            a_lv = 1'b0; step();
            a_ld = {AC{8'(k + 1)}}; a_lv = 1'b1; step();
        end
        a_lv = 1'b0; exp_lr = 1'b0;
        check_tile_a(ld_exp);

        // non-square transpose is rejected
        push_ev(EV_ERR, {AROW{1'b0}}, 1'b0);
        a_tr = 1'b1; step(); a_tr = 1'b0;
        check_tile_a(ld_exp);

        // shift_up wins over shift_left
        push_ev(EV_ERR, {AROW{1'b0}}, 1'b0);
        a_su = 1'b1; a_sl = 1'b1; step(); a_su = 1'b0; a_sl = 1'b0;
        for (int c = 0; c < AC; c++) begin
            exp[(0*AC+c)*BW +: BW] = 8'd2;
            exp[(1*AC+c)*BW +: BW] = 8'd3;
            exp[(2*AC+c)*BW +: BW] = 8'd4;
            exp[(3*AC+c)*BW +: BW] = 8'hA5;
        end
        check_tile_a(exp);
        a_sl = 1'b1; step(); a_sl = 1'b0;
        for (int r = 0; r < AR; r++) exp[(r*AC+AC-1)*BW +: BW] = 8'hA5;
        check_tile_a(exp);

        // init aborts a half-finished load
        a_ls = 1'b1; step(); a_ls = 1'b0; exp_lr = 1'b1;
        a_ld = {AC{8'h11}}; a_lv = 1'b1; step(); step(); a_lv = 1'b0;
        a_init = 1'b1; step(); a_init = 1'b0; exp_lr = 1'b0;
        check_tile_a({AC*AR{8'h3C}});

        // reset in the middle of a stalled store
        a_ss = 1'b1; step(); a_ss = 1'b0; exp_sv = 1'b1;
        step(); step();
        rstnn = 1'b0; exp_sv = 1'b0;
        check_tile_a({ATILE{1'b0}});
        rstnn = 1'b1;
        repeat (3) step();

        checks++;
        if (ev_q.size() != 0 || tile_q.size() != 0 || btile_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d/%0d/%0d pending want 0/0/0",
                     ev_q.size(), tile_q.size(), btile_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
